// File: rtl/instr_encode_loader.sv
// Packs addi (I-type) / bne (B-type) requests into RV32I words and writes them
// sequentially into instruction memory, one request per valid/ready handshake.
module instr_encode_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  fmt,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [31:0]           imm,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  err,
  output logic                  full
);

  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FULL} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [31:0]           enc_word;
  logic                  legal;

  // Encode the presented request and range-check its immediate.
  always_comb begin
    enc_word = '0;
    legal    = 1'b0;
    if (fmt) begin
      enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011};
      legal    = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
    end else begin
      enc_word = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
      legal    = (imm[31:11] == '0) || (imm[31:11] == '1);
    end
  end

  // ptr is the next free word; wr_addr keeps the last written address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= BASE;
      wr_data  <= '0;
      err      <= 1'b0;
      full     <= 1'b0;
      ptr      <= BASE;
    end else begin
      wr_en <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            if (legal) begin
              wr_en    <= 1'b1;
              wr_addr  <= ptr;
              wr_data  <= enc_word;
              in_ready <= 1'b0;
              state    <= S_WRITE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (wr_addr == LAST_ADDR) begin
            full     <= 1'b1;
            in_ready <= 1'b0;
            state    <= S_FULL;
          end else begin
            ptr      <= ptr + STEP;
            in_ready <= 1'b1;
            state    <= S_IDLE;
          end
        end
        S_FULL: begin
          in_ready <= 1'b0;
        end
        default: begin
          in_ready <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: encodings, legality, addressing,
// fill-up on a small memory and reset during a write.
module tb_instr_encode_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, fmt, in_ready, wr_en, err, full;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm, wr_data;
  logic [7:0]  wr_addr;

  logic        rst4, in_valid4, fmt4, in_ready4, wr_en4, err4, full4;
  logic [4:0]  rd4, rs14, rs24;
  logic [31:0] imm4, wr_data4;
  logic [3:0]  wr_addr4;

  int checks = 0;
  int errors = 0;

  instr_encode_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .err(err), .full(full)
  );

  instr_encode_loader #(.ADDR_WIDTH(4), .BASE_ADDR(0)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4), .fmt(fmt4),
    .rd(rd4), .rs1(rs14), .rs2(rs24), .imm(imm4), .wr_en(wr_en4), .wr_addr(wr_addr4),
    .wr_data(wr_data4), .err(err4), .full(full4)
  );

  // Independent B-type immediate decode, as the core's extender does it.
  function automatic logic [31:0] dec_b(input logic [31:0] w);
    return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  // Drive one request on the main instance; returns #1 after the handshake edge.
  task automatic send(input logic f, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im);
    int waited = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_timeout got %b exp 1", in_ready); end
    in_valid = 1'b1; fmt = f; rd = d; rs1 = s1; rs2 = s2; imm = im;
    @(posedge clk);
    #1;
    in_valid = 1'b0; imm = 32'hDEAD_BEEF; rd = '0; rs1 = '0; rs2 = '0; fmt = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rst4 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b exp 0", wr_en); end
    checks++; if (wr_addr !== 8'h00) begin errors++; $display("FAIL rst_wr_addr got %h exp 00", wr_addr); end
    checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL rst_wr_data got %h exp 0", wr_data); end
    checks++; if (err !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL rst_err_full got %b%b exp 00", err, full); end
    @(posedge clk); #1;
    rst = 1'b0; rst4 = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", in_ready); end
  endtask

  task automatic test_addi;
    send(1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    @(negedge clk);
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL t1_wr_en got %b exp 1", wr_en); end
    checks++; if (wr_addr !== 8'h00) begin errors++; $display("FAIL t1_wr_addr got %h exp 00", wr_addr); end
    checks++; if (wr_data !== 32'h00500093) begin errors++; $display("FAIL t1_wr_data got %h exp 00500093", wr_data); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL t1_err got %b exp 0", err); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL t1_busy got %b exp 0", in_ready); end
    @(negedge clk);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL t1_one_cycle got %b exp 0", wr_en); end
    checks++; if (wr_data !== 32'h00500093) begin errors++; $display("FAIL t1_hold got %h exp 00500093", wr_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t1_ready_back got %b exp 1", in_ready); end
  endtask

  task automatic test_bne;
    send(1'b1, 5'd0, 5'd1, 5'd2, -32'sd8);
    @(negedge clk);
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL t2_wr_en got %b exp 1", wr_en); end
    checks++; if (wr_addr !== 8'h04) begin errors++; $display("FAIL t2_wr_addr got %h exp 04", wr_addr); end
    checks++; if (wr_data !== 32'hFE209CE3) begin errors++; $display("FAIL t2_wr_data got %h exp FE209CE3", wr_data); end
    checks++; if (dec_b(wr_data) !== 32'hFFFFFFF8) begin errors++; $display("FAIL t2_roundtrip got %h exp FFFFFFF8", dec_b(wr_data)); end
  endtask

  task automatic test_illegal;
    logic [31:0] bad_imm [2];
    logic        bad_fmt [2];
    bad_imm[0] = 32'd2048; bad_fmt[0] = 1'b0;
    bad_imm[1] = 32'd3;    bad_fmt[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send(bad_fmt[i], 5'd3, 5'd1, 5'd2, bad_imm[i]);
      @(negedge clk);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL t3_err[%0d] got %b exp 1", i, err); end
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL t3_no_write[%0d] got %b exp 0", i, wr_en); end
      checks++; if (wr_addr !== 8'h04) begin errors++; $display("FAIL t3_addr[%0d] got %h exp 04", i, wr_addr); end
      @(negedge clk);
      checks++; if (err !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL t3_pulse[%0d] got err=%b wr_en=%b exp 0 0", i, err, wr_en); end
    end
  endtask

  task automatic test_boundaries;
    logic        b_fmt  [3];
    logic [31:0] b_imm  [3];
    logic [31:0] b_word [3];
    b_fmt[0] = 1'b0; b_imm[0] = -32'sd2048; b_word[0] = 32'h80000093;
    b_fmt[1] = 1'b1; b_imm[1] = 32'd4094;   b_word[1] = 32'h7E419FE3;
    b_fmt[2] = 1'b1; b_imm[2] = -32'sd4096; b_word[2] = 32'h80419063;
    for (int i = 0; i < 3; i++) begin
      send(b_fmt[i], 5'd1, (b_fmt[i] ? 5'd3 : 5'd0), 5'd4, b_imm[i]);
      @(negedge clk);
      checks++; if (wr_en !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL t4_accept[%0d] got wr_en=%b err=%b exp 1 0", i, wr_en, err); end
      checks++; if (wr_addr !== 8'(8 + 4 * i)) begin errors++; $display("FAIL t4_addr[%0d] got %h exp %h", i, wr_addr, 8'(8 + 4 * i)); end
      checks++; if (wr_data !== b_word[i]) begin errors++; $display("FAIL t4_data[%0d] got %h exp %h", i, wr_data, b_word[i]); end
      if (b_fmt[i]) begin
        checks++; if (dec_b(wr_data) !== b_imm[i]) begin errors++; $display("FAIL t4_roundtrip[%0d] got %h exp %h", i, dec_b(wr_data), b_imm[i]); end
      end
    end
  endtask

  task automatic test_fill;
    logic [31:0] exp_word [4];
    int waited;
    exp_word[0] = 32'h00000093; exp_word[1] = 32'h00100113;
    exp_word[2] = 32'h00200193; exp_word[3] = 32'h00300213;
    for (int i = 0; i < 4; i++) begin
      waited = 0;
      @(negedge clk);
      while (in_ready4 !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
      checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL t5_ready_timeout[%0d] got %b exp 1", i, in_ready4); end
      in_valid4 = 1'b1; fmt4 = 1'b0; rd4 = 5'(i + 1); rs14 = 5'd0; rs24 = 5'd0; imm4 = 32'(i);
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      @(negedge clk);
      checks++; if (wr_en4 !== 1'b1 || wr_addr4 !== 4'(4 * i)) begin errors++; $display("FAIL t5_write[%0d] got wr_en=%b addr=%h exp 1 %h", i, wr_en4, wr_addr4, 4'(4 * i)); end
      checks++; if (wr_data4 !== exp_word[i]) begin errors++; $display("FAIL t5_data[%0d] got %h exp %h", i, wr_data4, exp_word[i]); end
    end
    @(negedge clk);
    checks++; if (full4 !== 1'b1 || in_ready4 !== 1'b0) begin errors++; $display("FAIL t5_full got full=%b ready=%b exp 1 0", full4, in_ready4); end
    in_valid4 = 1'b1; imm4 = 32'd7;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (wr_en4 !== 1'b0 || wr_addr4 !== 4'hC || full4 !== 1'b1) begin errors++; $display("FAIL t5_blocked[%0d] got wr_en=%b addr=%h full=%b exp 0 c 1", c, wr_en4, wr_addr4, full4); end
    end
    in_valid4 = 1'b0;
  endtask

  task automatic test_reset_in_write;
    send(1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL t6_wr_en got %b exp 0", wr_en); end
    checks++; if (wr_addr !== 8'h00 || full !== 1'b0) begin errors++; $display("FAIL t6_state got addr=%h full=%b exp 00 0", wr_addr, full); end
    send(1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    @(negedge clk);
    checks++; if (wr_en !== 1'b1 || wr_addr !== 8'h00) begin errors++; $display("FAIL t6_rewrite got wr_en=%b addr=%h exp 1 00", wr_en, wr_addr); end
    checks++; if (wr_data !== 32'h00500093) begin errors++; $display("FAIL t6_data got %h exp 00500093", wr_data); end
  endtask

  initial begin
    in_valid = 1'b0; fmt = 1'b0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    in_valid4 = 1'b0; fmt4 = 1'b0; rd4 = '0; rs14 = '0; rs24 = '0; imm4 = '0;
    rst = 1'b1; rst4 = 1'b1;
    test_reset;
    test_addi;
    test_bne;
    test_illegal;
    test_boundaries;
    test_fill;
    test_reset_in_write;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
